rv_multicycle_ctrl: RTL and testbench

//  Multicycle control FSM for the RV32I core datapath. Sequences fetch/decode/exec/mem/writeback.

---
 rtl/rv_ctrl_pkg.sv | 47 ++++
 rtl/rv_opcode_classify.sv | 63 ++++++
 rtl/rv_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared types and constants for the RV32I multicycle control path.
// Also used by the immediate generator and the datapath.
package rv_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        FAULT  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_SHAMT = 3'd2,
        IMM_S     = 3'd3,
        IMM_B     = 3'd4
    } imm_fmt_t;

    typedef enum logic [2:0] {
        CLS_NONE   = 3'd0,
        CLS_OP     = 3'd1,
        CLS_OPIMM  = 3'd2,
        CLS_LOAD   = 3'd3,
        CLS_STORE  = 3'd4,
        CLS_BRANCH = 3'd5
    } instr_class_t;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] FC_NONE    = 2'd0;
    localparam logic [1:0] FC_ILLEGAL = 2'd1;
    localparam logic [1:0] FC_IMEM_TO = 2'd2;
    localparam logic [1:0] FC_DMEM_TO = 2'd3;

    // SLLI/SRLI/SRAI take a zero-extended 5-bit shift amount instead of a full I immediate
    function automatic logic is_shift_funct3(input logic [2:0] funct3);
        return (funct3 == 3'b001) || (funct3 == 3'b101);
    endfunction

endpackage

// File: rtl/rv_opcode_classify.sv
// Combinational instruction classifier: opcode/funct3 -> class, immediate format, illegal flag.
module rv_opcode_classify
    import rv_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [2:0]  cls,
    output logic [2:0]  imm_fmt,
    output logic        illegal
);

    instr_class_t cls_s;
    imm_fmt_t     fmt_s;
    logic         illegal_s;
    logic [6:0]   opcode_s;
    logic [2:0]   funct3_s;
    logic         instr_unused_s;

    assign opcode_s       = instr[6:0];
    assign funct3_s       = instr[14:12];
    // Register indices and immediate payload are the datapath's business, not ours
    assign instr_unused_s = ^{instr[31:15], instr[11:7]};

    // Map the opcode onto an instruction class and the immediate format it needs
    always_comb begin
        cls_s     = CLS_NONE;
        fmt_s     = IMM_NONE;
        illegal_s = 1'b0;
        case (opcode_s)
            OPC_OPIMM: begin
                cls_s = CLS_OPIMM;
                if (is_shift_funct3(funct3_s)) begin
                    fmt_s = IMM_SHAMT;
                end else begin
                    fmt_s = IMM_I;
                end
            end
            OPC_LOAD: begin
                cls_s = CLS_LOAD;
                fmt_s = IMM_I;
            end
            OPC_STORE: begin
                cls_s = CLS_STORE;
                fmt_s = IMM_S;
            end
            OPC_BRANCH: begin
                cls_s = CLS_BRANCH;
                fmt_s = IMM_B;
            end
            OPC_OP: begin
                cls_s = CLS_OP;
                fmt_s = IMM_NONE;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    assign cls     = cls_s;
    assign imm_fmt = fmt_s;
    assign illegal = illegal_s;

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multicycle control FSM for the RV32I core: FETCH/DECODE/EXEC/MEM/WB with
// req/ack memory handshakes, memory timeout supervision and a terminal FAULT state.
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] instr,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        branch_taken,
    output logic        imem_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic [2:0]  imm_fmt,
    output logic        alu_src_imm,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        reg_we,
    output logic        wb_sel,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [2:0]  state_dbg
);

    localparam int              CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    state_t       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    instr_class_t cls_r, cls_nxt_s;
    imm_fmt_t     fmt_r, fmt_nxt_s;
    logic [1:0]   code_r, code_nxt_s;
    logic         fault_r;

    logic [2:0]   dec_cls_s;
    logic [2:0]   dec_fmt_s;
    logic         dec_illegal_s;

    logic imem_req_s, ir_we_s, pc_we_s, pc_src_s, alu_src_imm_s;
    logic dmem_req_s, dmem_we_s, reg_we_s, wb_sel_s;

    rv_opcode_classify u_classify (
        .instr   (instr),
        .cls     (dec_cls_s),
        .imm_fmt (dec_fmt_s),
        .illegal (dec_illegal_s)
    );

    // State, timeout counter, decoded-instruction and fault registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= FETCH;
            cnt_r   <= CNT_ZERO;
            cls_r   <= CLS_NONE;
            fmt_r   <= IMM_NONE;
            code_r  <= FC_NONE;
            fault_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            cls_r   <= cls_nxt_s;
            fmt_r   <= fmt_nxt_s;
            code_r  <= code_nxt_s;
            fault_r <= (state_nxt_s == FAULT);
        end
    end

    // Next-state, timeout counting and decode capture; a late ack still beats the timeout
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = CNT_ZERO;
        cls_nxt_s   = cls_r;
        fmt_nxt_s   = fmt_r;
        code_nxt_s  = code_r;
        case (state_r)
            FETCH: begin
                if (imem_ack) begin
                    state_nxt_s = DECODE;
                end else if (cnt_r == CNT_LIMIT) begin
                    state_nxt_s = FAULT;
                    code_nxt_s  = FC_IMEM_TO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            DECODE: begin
                cls_nxt_s = instr_class_t'(dec_cls_s);
                fmt_nxt_s = imm_fmt_t'(dec_fmt_s);
                if (dec_illegal_s) begin
                    state_nxt_s = FAULT;
                    code_nxt_s  = FC_ILLEGAL;
                end else begin
                    state_nxt_s = EXEC;
                end
            end
            EXEC: begin
                case (cls_r)
                    CLS_OP, CLS_OPIMM:   state_nxt_s = WB;
                    CLS_LOAD, CLS_STORE: state_nxt_s = MEM;
                    CLS_BRANCH:          state_nxt_s = FETCH;
                    default: begin
                        // A class that never passed decode cannot execute safely
                        state_nxt_s = FAULT;
                        code_nxt_s  = FC_ILLEGAL;
                    end
                endcase
            end
            MEM: begin
                if (dmem_ack) begin
                    if (cls_r == CLS_LOAD) begin
                        state_nxt_s = WB;
                    end else begin
                        state_nxt_s = FETCH;
                    end
                end else if (cnt_r == CNT_LIMIT) begin
                    state_nxt_s = FAULT;
                    code_nxt_s  = FC_DMEM_TO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            WB: begin
                state_nxt_s = FETCH;
            end
            FAULT: begin
                state_nxt_s = FAULT;
            end
            default: begin
                // Corrupted state encoding: park in the safe terminal state
                state_nxt_s = FAULT;
                code_nxt_s  = FC_ILLEGAL;
            end
        endcase
    end

    // Per-state strobes; acks only matter in the state that owns the matching request
    always_comb begin
        imem_req_s    = 1'b0;
        ir_we_s       = 1'b0;
        pc_we_s       = 1'b0;
        pc_src_s      = 1'b0;
        alu_src_imm_s = 1'b0;
        dmem_req_s    = 1'b0;
        dmem_we_s     = 1'b0;
        reg_we_s      = 1'b0;
        wb_sel_s      = 1'b0;
        case (state_r)
            FETCH: begin
                imem_req_s = 1'b1;
                ir_we_s    = imem_ack;
            end
            DECODE: begin
                imem_req_s = 1'b0;
            end
            EXEC: begin
                alu_src_imm_s = (cls_r != CLS_OP) && (cls_r != CLS_BRANCH);
                if (cls_r == CLS_BRANCH) begin
                    pc_we_s  = 1'b1;
                    pc_src_s = branch_taken;
                end else begin
                    pc_we_s  = 1'b0;
                    pc_src_s = 1'b0;
                end
            end
            MEM: begin
                dmem_req_s = 1'b1;
                dmem_we_s  = (cls_r == CLS_STORE);
                if (dmem_ack && (cls_r == CLS_STORE)) begin
                    pc_we_s = 1'b1;
                end else begin
                    pc_we_s = 1'b0;
                end
            end
            WB: begin
                reg_we_s = 1'b1;
                wb_sel_s = (cls_r == CLS_LOAD);
                pc_we_s  = 1'b1;
            end
            FAULT: begin
                imem_req_s = 1'b0;
            end
            default: begin
                imem_req_s = 1'b0;
            end
        endcase
    end

    // Holding reset_n low silences every output immediately, aborting any transaction in flight
    assign imem_req    = reset_n & imem_req_s;
    assign ir_we       = reset_n & ir_we_s;
    assign pc_we       = reset_n & pc_we_s;
    assign pc_src      = reset_n & pc_src_s;
    assign alu_src_imm = reset_n & alu_src_imm_s;
    assign dmem_req    = reset_n & dmem_req_s;
    assign dmem_we     = reset_n & dmem_we_s;
    assign reg_we      = reset_n & reg_we_s;
    assign wb_sel      = reset_n & wb_sel_s;
    assign fault       = reset_n & fault_r;
    assign imm_fmt     = reset_n ? fmt_r : IMM_NONE;
    assign fault_code  = reset_n ? code_r : FC_NONE;
    assign state_dbg   = reset_n ? state_r : FETCH;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl: a hand-written vector table, then
// directed and random instruction streams expanded into per-cycle vectors by a
// transaction-level reference model.
module tb_rv_multicycle_ctrl;
    import rv_ctrl_pkg::*;

    localparam int T = 4;
    localparam int K_OP = 0, K_OPIMM = 1, K_LOAD = 2, K_STORE = 3, K_BRANCH = 4;
    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h00012083;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_SLLI = 32'h00309093;
    localparam logic [31:0] I_BAD  = 32'h0000007F;
    localparam logic [31:0] I_SW   = 32'h00112023;

    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       pc_we;
        logic       pc_src;
        logic [2:0] imm_fmt;
        logic       alu_src_imm;
        logic       dmem_req;
        logic       dmem_we;
        logic       reg_we;
        logic       wb_sel;
        logic       fault;
        logic [1:0] fault_code;
        logic [2:0] state_dbg;
    } outs_t;

    typedef struct {
        logic        rst_n;
        logic [31:0] instr;
        logic        iack;
        logic        dack;
        logic        bt;
        outs_t       exp;
        outs_t       care;
        int          id;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] instr = 32'd0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        branch_taken = 1'b0;
    logic        imem_req, ir_we, pc_we, pc_src, alu_src_imm;
    logic        dmem_req, dmem_we, reg_we, wb_sel, fault;
    logic [2:0]  imm_fmt;
    logic [1:0]  fault_code;
    logic [2:0]  state_dbg;

    vec_t        vq[$];
    vec_t        tbl[7];
    logic [2:0]  m_fmt = 3'd0;
    int          cur_id = 0;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    rv_multicycle_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .instr        (instr),
        .imem_ack     (imem_ack),
        .dmem_ack     (dmem_ack),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .imm_fmt      (imm_fmt),
        .alu_src_imm  (alu_src_imm),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .fault        (fault),
        .fault_code   (fault_code),
        .state_dbg    (state_dbg)
    );

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic vec_t mkv(logic rst, logic [31:0] ins, logic ia, logic da, outs_t e);
        vec_t v;
        v.rst_n = rst; v.instr = ins; v.iack = ia; v.dack = da; v.bt = 1'b0;
        v.exp = e; v.care = '1; v.id = 1;
        return v;
    endfunction

    function automatic void push(logic rst, logic [31:0] ins, logic ia, logic da, logic b,
                                 outs_t e, outs_t c);
        vec_t v;
        v.rst_n = rst; v.instr = ins; v.iack = ia; v.dack = da; v.bt = b;
        v.exp = e; v.care = c; v.id = cur_id;
        vq.push_back(v);
    endfunction

    function automatic outs_t base(state_t st);
        outs_t e;
        e = '0;
        e.state_dbg = st;
        e.imm_fmt = m_fmt;
        return e;
    endfunction

    // Instruction semantics straight from the opcode table
    function automatic void spec_decode(input logic [31:0] ins, output int kind,
                                        output logic [2:0] fmt, output bit bad);
        logic [6:0] op;
        logic [2:0] f3;
        op = ins[6:0]; f3 = ins[14:12];
        bad = 1'b0; kind = K_OP; fmt = IMM_NONE;
        if (op == 7'h13) begin
            kind = K_OPIMM;
            fmt = (f3 == 3'd1 || f3 == 3'd5) ? IMM_SHAMT : IMM_I;
        end else if (op == 7'h03) begin
            kind = K_LOAD; fmt = IMM_I;
        end else if (op == 7'h23) begin
            kind = K_STORE; fmt = IMM_S;
        end else if (op == 7'h63) begin
            kind = K_BRANCH; fmt = IMM_B;
        end else if (op == 7'h33) begin
            kind = K_OP; fmt = IMM_NONE;
        end else begin
            bad = 1'b1;
        end
    endfunction

    // Cycle with reset_n low: everything silent; afterwards fmt returns to NONE
    function automatic void push_reset(logic da);
        outs_t e, c;
        e = '0; c = '1;
        push(1'b0, $urandom, rb(), da, rb(), e, c);
        m_fmt = IMM_NONE;
    endfunction

    // Three cycles parked in FAULT, then a reset to recover
    function automatic void fault_tail(logic [1:0] code);
        outs_t e, c;
        c = '1; c.imm_fmt = 3'd0;
        for (int k = 0; k < 3; k++) begin
            e = base(FAULT); e.fault = 1'b1; e.fault_code = code;
            push(1'b1, $urandom, rb(), rb(), rb(), e, c);
        end
        push_reset(rb());
    endfunction

    // One instruction as a transaction. iwait/dwait = idle cycles before the ack
    // (>= T: never acks). dwait < 0: reset asserted on the third MEM cycle.
    // btm: 0/1 forced branch result, 2 random.
    function automatic void gen_instr(logic [31:0] ins, int iwait, int dwait, int btm);
        outs_t e, c;
        logic ack, bt;
        logic [2:0] nf;
        int kind;
        bit bad;
        c = '1;
        for (int k = 0; k < T; k++) begin
            ack = (k == iwait);
            e = base(FETCH); e.imem_req = 1'b1; e.ir_we = ack;
            push(1'b1, $urandom, ack, rb(), rb(), e, c);
            if (ack) break;
        end
        if (iwait >= T) begin
            fault_tail(FC_IMEM_TO);
            return;
        end
        e = base(DECODE);
        push(1'b1, ins, rb(), rb(), rb(), e, c);
        spec_decode(ins, kind, nf, bad);
        if (bad) begin
            fault_tail(FC_ILLEGAL);
            return;
        end
        m_fmt = nf;
        bt = (btm == 2) ? rb() : (btm == 1);
        e = base(EXEC);
        e.alu_src_imm = !(kind == K_OP || kind == K_BRANCH);
        if (kind == K_BRANCH) begin
            e.pc_we = 1'b1; e.pc_src = bt;
        end
        push(1'b1, ins, rb(), rb(), bt, e, c);
        if (kind == K_BRANCH) return;
        if (kind == K_LOAD || kind == K_STORE) begin
            for (int k = 0; k < T; k++) begin
                if (dwait < 0 && k == 2) begin
                    push_reset(1'b1);
                    return;
                end
                ack = (k == dwait);
                e = base(MEM); e.dmem_req = 1'b1; e.dmem_we = (kind == K_STORE);
                e.pc_we = ack && (kind == K_STORE);
                push(1'b1, ins, rb(), ack, rb(), e, c);
                if (ack) break;
            end
            if (dwait >= T) begin
                fault_tail(FC_DMEM_TO);
                return;
            end
            if (kind == K_STORE) return;
        end
        e = base(WB); e.reg_we = 1'b1; e.pc_we = 1'b1; e.wb_sel = (kind == K_LOAD);
        push(1'b1, ins, rb(), rb(), rb(), e, c);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [2:0] f;
        int kind;
        bit bad;
        r = $urandom;
        case ($urandom_range(0, 11))
            0, 1:    r[6:0] = 7'h13;
            2:       begin r[6:0] = 7'h13; r[14:12] = rb() ? 3'b001 : 3'b101; end
            3, 4:    r[6:0] = 7'h03;
            5, 6:    r[6:0] = 7'h23;
            7, 8:    r[6:0] = 7'h63;
            9, 10:   r[6:0] = 7'h33;
            default: begin
                r[6:0] = 7'($urandom);
                spec_decode(r, kind, f, bad);
                if (!bad) r[6:0] = 7'h7F;
            end
        endcase
        return r;
    endfunction

    initial begin
        outs_t e;
        outs_t xe;
        logic [17:0] a, x, m;
        int iw, dw;

        // ADDI with single-cycle acks, written out cycle by cycle
        e = '0;                                                     tbl[0] = mkv(1'b0, 32'd0,        1'b0, 1'b0, e);
        e = '0; e.imem_req = 1'b1; e.ir_we = 1'b1; e.state_dbg = FETCH;
                                                                    tbl[1] = mkv(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, e);
        e = '0; e.state_dbg = DECODE;                               tbl[2] = mkv(1'b1, I_ADDI,       1'b0, 1'b0, e);
        e = '0; e.state_dbg = EXEC; e.alu_src_imm = 1'b1; e.imm_fmt = IMM_I;
                                                                    tbl[3] = mkv(1'b1, I_ADDI,       1'b0, 1'b0, e);
        e = '0; e.state_dbg = WB; e.reg_we = 1'b1; e.pc_we = 1'b1; e.imm_fmt = IMM_I;
                                                                    tbl[4] = mkv(1'b1, I_ADDI,       1'b0, 1'b0, e);
        e = '0; e.state_dbg = FETCH; e.imem_req = 1'b1; e.imm_fmt = IMM_I;
                                                                    tbl[5] = mkv(1'b1, 32'h12345678, 1'b0, 1'b1, e);
        e = '0;                                                     tbl[6] = mkv(1'b0, I_ADDI,       1'b1, 1'b1, e);
        for (int i = 0; i < 7; i++) vq.push_back(tbl[i]);
        m_fmt = IMM_NONE;

        cur_id = 2; gen_instr(I_LW,   0, 2, 2);
        cur_id = 3; gen_instr(I_BEQ,  0, 0, 1);
                    gen_instr(I_BEQ,  1, 0, 0);
        cur_id = 4; gen_instr(I_SLLI, 0, 0, 2);
                    gen_instr(I_BAD,  0, 0, 2);
        cur_id = 5; gen_instr(I_ADDI, T, 0, 2);
                    gen_instr(I_ADDI, T - 1, 0, 2);
                    gen_instr(I_SW,   0, T, 2);
                    gen_instr(I_LW,   0, T - 1, 2);
        cur_id = 6; gen_instr(I_SW,   0, -1, 2);
                    gen_instr(I_ADDI, 0, 0, 2);
        cur_id = 7;
        for (int n = 0; n < 300; n++) begin
            iw = ($urandom_range(0, 19) == 0) ? T : $urandom_range(0, T - 1);
            dw = $urandom_range(0, 19);
            if (dw == 0) dw = T;
            else if (dw == 1) dw = -1;
            else dw = $urandom_range(0, T - 1);
            gen_instr(rand_instr(), iw, dw, 2);
        end

        @(posedge clk); #1;
        for (int i = 0; i < vq.size(); i++) begin
            reset_n      = vq[i].rst_n;
            instr        = vq[i].instr;
            imem_ack     = vq[i].iack;
            dmem_ack     = vq[i].dack;
            branch_taken = vq[i].bt;
            #4;
            a = {imem_req, ir_we, pc_we, pc_src, imm_fmt, alu_src_imm, dmem_req,
                 dmem_we, reg_we, wb_sel, fault, fault_code, state_dbg};
            x = vq[i].exp;
            m = vq[i].care;
            xe = vq[i].exp;
            compared++;
            if (((a ^ x) & m) != 18'd0) begin
                mismatched++;
                $display("FAIL outputs vec %0d test %0d: got %b want %b (mask %b)",
                         i, vq[i].id, a, x, m);
            end
            if (vq[i].rst_n == 1'b0) begin
                compared++;
                if (a != 18'd0) begin
                    mismatched++;
                    $display("FAIL reset-state vec %0d test %0d: outputs %b not all zero",
                             i, vq[i].id, a);
                end
            end
            if (xe.state_dbg == FAULT && (xe.fault_code == FC_IMEM_TO || xe.fault_code == FC_DMEM_TO)) begin
                compared++;
                if (fault !== 1'b1 || fault_code !== xe.fault_code) begin
                    mismatched++;
                    $display("FAIL expired-wait vec %0d test %0d: fault=%b code=%0d want fault=1 code=%0d",
                             i, vq[i].id, fault, fault_code, xe.fault_code);
                end
            end
            @(posedge clk); #1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
